// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: miniRISC multi-cycle control FSM (fetch/decode/exec/mem/wb) with req/ready memory handshake
// Ports: clk, rst (sync, active-low); instr (IR, opcode [31:26]), zero_flag, mem_ready in;
//   mem_req/mem_we/mem_addr_sel, ir_we, pc_we/pc_src, reg_we/wb_from_mem, alu_src_imm/imm_zext,
//   halted, illegal (sticky), state (debug) out.
// Define MC_PERF_CNT_EN to add cycle_cnt/instr_cnt performance counters.
module multicycle_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        zero_flag,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        reg_we,
  output logic        wb_from_mem,
  output logic        alu_src_imm,
  output logic        imm_zext,
  output logic        halted,
  output logic        illegal,
  output logic [2:0]  state
`ifdef MC_PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instr_cnt
`endif
);
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6
  } state_t;
  localparam logic [5:0] OP_SHIFT = 6'd2;
  localparam logic [5:0] OP_LD    = 6'd3;
  localparam logic [5:0] OP_ST    = 6'd4;
  localparam logic [5:0] OP_BR    = 6'd5;
  localparam logic [5:0] OP_JMP   = 6'd6;
  localparam logic [5:0] OP_HALT  = 6'd7;
  state_t state_q, state_d;
  logic illegal_q, illegal_d;
  logic [5:0] op;
  logic in_dx;
  logic unused_instr;
  assign op = instr[31:26];
  assign unused_instr = ^instr[25:0];
  assign in_dx = state_q == DECODE || state_q == EXEC || state_q == MEM || state_q == WB;
  assign alu_src_imm = in_dx && op >= 6'd1 && op <= OP_ST;
  assign imm_zext = in_dx && op == OP_SHIFT;
  assign state = state_q;
  assign illegal = illegal_q;
  always_comb begin
    state_d = state_q;
    mem_req = 1'b0;
    mem_we = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we = 1'b0;
    pc_we = 1'b0;
    pc_src = 2'b00;
    reg_we = 1'b0;
    wb_from_mem = 1'b0;
    halted = 1'b0;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        mem_req = 1'b1;
        ir_we = mem_ready;
        pc_we = mem_ready;
        state_d = mem_ready ? DECODE : FETCH;
      end
      DECODE: state_d = op >= OP_HALT ? HALT : EXEC;
      EXEC: begin
        pc_we = op == OP_JMP || (op == OP_BR && zero_flag);
        pc_src = op == OP_JMP ? 2'b10 : op == OP_BR ? 2'b01 : 2'b00;
        state_d = (op == OP_BR || op == OP_JMP) ? FETCH : (op == OP_LD || op == OP_ST) ? MEM : WB;
      end
      MEM: begin
        mem_req = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we = op == OP_ST;
        state_d = !mem_ready ? MEM : op == OP_LD ? WB : FETCH;
      end
      WB: begin
        reg_we = 1'b1;
        wb_from_mem = op == OP_LD;
        state_d = FETCH;
      end
      HALT: halted = 1'b1;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    illegal_d = illegal_q | (state_q == DECODE && op > OP_HALT);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      illegal_q <= illegal_d;
    end
  end
`ifdef MC_PERF_CNT_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d, instr_cnt_q, instr_cnt_d;
  logic retire;
  assign retire = (state_d == FETCH && (state_q == EXEC || state_q == MEM || state_q == WB)) ||
                  (state_q == DECODE && op == OP_HALT);
  always_comb begin
    cycle_cnt_d = cycle_cnt_q + {31'd0, state_q != IDLE && state_q != HALT};
    instr_cnt_d = instr_cnt_q + {31'd0, retire};
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end
  assign cycle_cnt = cycle_cnt_q;
  assign instr_cnt = instr_cnt_q;
`endif
endmodule
